// File: rtl/parking_gate_controller.sv
// Parking lot gate controller: arbitrates debounced entry/exit pulses, tracks occupancy
// against CAPACITY and holds the matching gate open for OPEN_CYCLES clock cycles.
module parking_gate_controller #(
    parameter int CLK_FREQUENCY = 40_000_000,
    parameter int OPEN_SECONDS  = 3,
    parameter int CAPACITY      = 8,
    localparam int OPEN_CYCLES  = CLK_FREQUENCY * OPEN_SECONDS,
    localparam int OCC_W        = $clog2(CAPACITY + 1),
    localparam int TMR_W        = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic             entry_gate,
    output logic             exit_gate,
    output logic [OCC_W-1:0] occupancy,
    output logic [OCC_W-1:0] free_spaces,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_CAP  = OCC_W'(CAPACITY);

    state_t             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [OCC_W-1:0]   occ_q;
    logic               pend_ent_q;
    logic               pend_ext_q;
    logic               entry_gate_q;
    logic               exit_gate_q;
    logic               reject_q;
    logic               busy_q;

    logic               ent_d;
    logic               ext_d;
    logic               full_d;
    logic               empty_d;

    // Handshake: requests are single-cycle pulses with no back-pressure. Each pulse is
    // serviced in IDLE, parked in its one-deep pending bit while a gate is open, or
    // answered with a one-cycle reject when the lot cannot take it.
    always_comb begin
        ent_d   = entry_req | pend_ent_q;
        ext_d   = exit_req | pend_ext_q;
        full_d  = (occ_q == OCC_CAP);
        empty_d = (occ_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            occ_q        <= '0;
            pend_ent_q   <= 1'b0;
            pend_ext_q   <= 1'b0;
            entry_gate_q <= 1'b0;
            exit_gate_q  <= 1'b0;
            reject_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ext_d) begin
                        // Exit wins; a concurrent entry waits one IDLE cycle in its pending bit.
                        pend_ext_q <= 1'b0;
                        pend_ent_q <= ent_d;
                        if (!empty_d) begin
                            state_q     <= EXIT_OPEN;
                            occ_q       <= occ_q - 1'b1;
                            exit_gate_q <= 1'b1;
                            busy_q      <= 1'b1;
                            timer_q     <= '0;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end else if (ent_d) begin
                        pend_ent_q <= 1'b0;
                        if (!full_d) begin
                            state_q      <= ENTRY_OPEN;
                            occ_q        <= occ_q + 1'b1;
                            entry_gate_q <= 1'b1;
                            busy_q       <= 1'b1;
                            timer_q      <= '0;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                ENTRY_OPEN, EXIT_OPEN: begin
                    if (entry_req) pend_ent_q <= 1'b1;
                    if (exit_req)  pend_ext_q <= 1'b1;
                    if (timer_q == TMR_LAST) begin
                        state_q      <= IDLE;
                        entry_gate_q <= 1'b0;
                        exit_gate_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        timer_q      <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    entry_gate_q <= 1'b0;
                    exit_gate_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    timer_q      <= '0;
                end
            endcase
        end
    end

    assign entry_gate  = entry_gate_q;
    assign exit_gate   = exit_gate_q;
    assign occupancy   = occ_q;
    assign free_spaces = OCC_CAP - occ_q;
    assign full        = full_d;
    assign empty       = empty_d;
    assign reject      = reject_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed request pulses push expected gate/reject
// events into a queue; a monitor pops and compares each event the DUT presents.
module tb_parking_gate_controller;

    localparam int W = 15;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       entry_gate;
    logic       exit_gate;
    logic [3:0] occupancy;
    logic [3:0] free_spaces;
    logic       full;
    logic       empty;
    logic       reject;
    logic       busy;
    logic [1:0] state_dbg;

    int tests;
    int fails;
    int occ_m;
    logic [W-1:0] exp_q[$];

    parking_gate_controller #(
        .CLK_FREQUENCY(10),
        .OPEN_SECONDS (1),
        .CAPACITY     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .entry_gate (entry_gate),
        .exit_gate  (exit_gate),
        .occupancy  (occupancy),
        .free_spaces(free_spaces),
        .full       (full),
        .empty      (empty),
        .reject     (reject),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Event record: {entry_rise, exit_rise, reject, occ, free, full, empty, gap}
    task automatic push_exp(input logic [2:0] kind, input int occ, input logic [1:0] gap);
        logic [3:0] o;
        logic [3:0] f;
        o = 4'(occ);
        f = 4'(8 - occ);
        exp_q.push_back({kind, o, f, (occ == 8), (occ == 0), gap});
    endtask

    // Monitor: samples on the falling edge and checks every presented event
    task automatic monitor();
        logic       prev_ent;
        logic       prev_ext;
        int         len;
        logic [1:0] gap;
        logic [W-1:0] obs;
        logic [W-1:0] exp_v;
        logic       ent_rise;
        logic       ext_rise;
        prev_ent = 1'b0;
        prev_ext = 1'b0;
        len      = 0;
        gap      = 2'd3;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_ent = 1'b0;
                prev_ext = 1'b0;
                len      = 0;
                gap      = 2'd3;
            end else begin
                ent_rise = entry_gate && !prev_ent;
                ext_rise = exit_gate && !prev_ext;
                if (ent_rise || ext_rise || reject) begin
                    obs = {ent_rise, ext_rise, reject, occupancy, free_spaces, full, empty, gap};
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_event: got 0x%0h, required no event", obs);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("event", 32'(obs), 32'(exp_v));
                    end
                end
                check("busy_gates", {30'd0, busy, entry_gate & exit_gate},
                      {30'd0, entry_gate | exit_gate, 1'b0});
                if (entry_gate || exit_gate) begin
                    len++;
                    gap = 2'd0;
                end else begin
                    if (prev_ent || prev_ext) begin
                        check("open_length", 32'(len), 32'd10);
                        len = 0;
                    end
                    if (gap != 2'd3) gap = gap + 2'd1;
                end
                prev_ent = entry_gate;
                prev_ext = exit_gate;
            end
        end
    endtask

    // Driver tasks; caller is always positioned 1ns after a rising edge
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ent, input logic ext);
        entry_req = ent;
        exit_req  = ext;
        @(posedge clk);
        #1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic do_entry();
        push_exp(3'b100, occ_m + 1, 2'd3);
        occ_m++;
        pulse(1'b1, 1'b0);
        cycles(14);
    endtask

    task automatic do_exit();
        push_exp(3'b010, occ_m - 1, 2'd3);
        occ_m--;
        pulse(1'b0, 1'b1);
        cycles(14);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        occ_m     = 0;
        reset     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        fork
            monitor();
        join_none

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_entry_gate", 32'(entry_gate), 32'd0);
        check("rst_exit_gate", 32'(exit_gate), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_free", 32'(free_spaces), 32'd8);
        check("rst_flags", {29'd0, empty, full, reject}, {29'd0, 3'b100});
        reset = 1'b1;
        cycles(2);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single entry
        push_exp(3'b100, 1, 2'd3);
        occ_m = 1;
        pulse(1'b1, 1'b0);
        check("single_gate", 32'(entry_gate), 32'd1);
        check("single_occ", 32'(occupancy), 32'd1);
        check("single_free", 32'(free_spaces), 32'd7);
        cycles(14);

        // Fill to capacity, then reject a ninth entry
        for (int i = 0; i < 7; i++) do_entry();
        check("full_flag", 32'(full), 32'd1);
        push_exp(3'b001, 8, 2'd3);
        pulse(1'b1, 1'b0);
        check("reject_no_gate", 32'(entry_gate), 32'd0);
        cycles(14);
        check("full_occ_held", 32'(occupancy), 32'd8);

        // Drain, then reject an exit from an empty lot
        for (int i = 0; i < 8; i++) do_exit();
        push_exp(3'b001, 0, 2'd3);
        pulse(1'b0, 1'b1);
        cycles(14);
        check("empty_occ_held", 32'(occupancy), 32'd0);

        // Simultaneous requests at occupancy 3
        for (int i = 0; i < 3; i++) do_entry();
        push_exp(3'b010, 2, 2'd3);
        push_exp(3'b100, 3, 2'd1);
        pulse(1'b1, 1'b1);
        check("simul_exit_first", 32'(exit_gate), 32'd1);
        cycles(30);
        check("simul_occ", 32'(occupancy), 32'd3);

        // Two extra entry pulses during an open gate collapse into one pending request
        push_exp(3'b100, 4, 2'd3);
        push_exp(3'b100, 5, 2'd1);
        pulse(1'b1, 1'b0);
        cycles(2);
        pulse(1'b1, 1'b0);
        cycles(2);
        pulse(1'b1, 1'b0);
        cycles(30);
        occ_m = 5;
        check("pending_occ", 32'(occupancy), 32'd5);

        // Reset during EXIT_OPEN with an entry pending
        push_exp(3'b010, 4, 2'd3);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        cycles(2);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_exit_gate", 32'(exit_gate), 32'd0);
        check("midrst_occ", 32'(occupancy), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_free", 32'(free_spaces), 32'd8);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        occ_m = 0;
        cycles(30);
        check("post_midrst_occ", 32'(occupancy), 32'd0);
        check("post_midrst_gate", 32'({entry_gate, exit_gate}), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
